sub_dispatch: RTL and testbench

Operand dispatcher and result collector wrapped around the 32-bit serial subtractor. It accepts operand triples (a, b, bin) on a valid/ready stream and buffers them in a small FIFO. It issues one `start` pulse per operation to the subtractor, waits for `done` with timeout protection, and returns diff/bout on a valid/ready result stream. It sits directly upstream of the subtractor, which it feeds, and directly downstream of it, consuming its results.

---
 rtl/sub_dispatch_if.sv | 43 ++++
 rtl/sub_dispatch.sv | 182 ++++++++++++++++++
 tb/tb_sub_dispatch.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_dispatch_if.sv
// Signal bundle between sub_dispatch, its operand producer, its result
// consumer and the serial subtractor it drives.
interface sub_dispatch_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_bin;

   logic             sub_start;
   logic [WIDTH-1:0] sub_a;
   logic [WIDTH-1:0] sub_b;
   logic             sub_bin;
   logic [WIDTH-1:0] sub_diff;
   logic             sub_bout;
   logic             sub_done;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_diff;
   logic             out_bout;
   logic             out_err;

   modport slave (
      input  in_valid, in_a, in_b, in_bin,
      output in_ready,
      output sub_start, sub_a, sub_b, sub_bin,
      input  sub_diff, sub_bout, sub_done,
      output out_valid, out_diff, out_bout, out_err,
      input  out_ready
   );

   modport master (
      output in_valid, in_a, in_b, in_bin,
      input  in_ready,
      input  sub_start, sub_a, sub_b, sub_bin,
      output sub_diff, sub_bout, sub_done,
      input  out_valid, out_diff, out_bout, out_err,
      output out_ready
   );
endinterface

// File: rtl/sub_dispatch.sv
// Operand FIFO plus issue/wait/hold sequencer wrapped around a serial subtractor;
// results are passed through untouched, or flagged with out_err on timeout.
module sub_dispatch #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 40
) (
   input  logic                   clk,
   input  logic                   reset,
   sub_dispatch_if.slave          bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int EW = 2 * WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      GUARD = 3'd2,
      WAIT  = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             sub_start_q, sub_start_d;
   logic [WIDTH-1:0] sub_a_q, sub_a_d;
   logic [WIDTH-1:0] sub_b_q, sub_b_d;
   logic             sub_bin_q, sub_bin_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_diff_q, out_diff_d;
   logic             out_bout_q, out_bout_d;
   logic             out_err_q, out_err_d;
   logic             busy_q, busy_d;
   logic             in_ready_s;
   logic             push_s;
   logic             pop_s;

   // No pass-through when full: readiness depends only on the stored count.
   assign in_ready_s = reset && (count_q < CW'(DEPTH));
   assign push_s     = bus.in_valid && in_ready_s;

   // Next-state computation for the FIFO and the issue/wait sequencer.
   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_d        = wr_q;
      rd_d        = rd_q;
      timer_d     = timer_q;
      sub_start_d = 1'b0;
      sub_a_d     = sub_a_q;
      sub_b_d     = sub_b_q;
      sub_bin_d   = sub_bin_q;
      out_valid_d = out_valid_q;
      out_diff_d  = out_diff_q;
      out_bout_d  = out_bout_q;
      out_err_d   = out_err_q;
      pop_s       = 1'b0;

      if (push_s) begin
         mem_d[wr_q] = {bus.in_bin, bus.in_b, bus.in_a};
         wr_d        = wr_q + PW'(1);
      end else begin
         wr_d        = wr_q;
      end

      case (state_q)
         IDLE: begin
            if (count_q != CW'(0)) begin
               pop_s                           = 1'b1;
               {sub_bin_d, sub_b_d, sub_a_d}   = mem_q[rd_q];
               rd_d                            = rd_q + PW'(1);
               sub_start_d                     = 1'b1;
               state_d                         = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            state_d = GUARD;
         end
         // A done left high by the previous operation may still be visible here.
         GUARD: begin
            timer_d = TW'(0);
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.sub_done) begin
               out_diff_d  = bus.sub_diff;
               out_bout_d  = bus.sub_bout;
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               out_diff_d  = bus.sub_diff;
               out_bout_d  = 1'b0;
               out_err_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any in-flight operation silently.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_q       <= '{default: '0};
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         timer_q     <= '0;
         sub_start_q <= 1'b0;
         sub_a_q     <= '0;
         sub_b_q     <= '0;
         sub_bin_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_diff_q  <= '0;
         out_bout_q  <= 1'b0;
         out_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         sub_start_q <= sub_start_d;
         sub_a_q     <= sub_a_d;
         sub_b_q     <= sub_b_d;
         sub_bin_q   <= sub_bin_d;
         out_valid_q <= out_valid_d;
         out_diff_q  <= out_diff_d;
         out_bout_q  <= out_bout_d;
         out_err_q   <= out_err_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.sub_start = sub_start_q;
   assign bus.sub_a     = sub_a_q;
   assign bus.sub_b     = sub_b_q;
   assign bus.sub_bin   = sub_bin_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_diff  = out_diff_q;
   assign bus.out_bout  = out_bout_q;
   assign bus.out_err   = out_err_q;
   assign busy          = busy_q;
   assign fifo_count    = count_q;
endmodule

// File: tb/tb_sub_dispatch.sv
// Scoreboard bench for sub_dispatch with a behavioural subtractor stub
// (normal, stale-done and never-done modes).
module tb_sub_dispatch;
   localparam int W   = 32;
   localparam int D   = 4;
   localparam int TO  = 40;
   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       busy;
   logic [2:0] fifo_count;

   sub_dispatch_if #(.WIDTH(W)) bus ();

   sub_dispatch #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .bus        (bus),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         err;
      bit           chk_diff;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total  = 0;
   int   bad    = 0;
   int   starts = 0;
   int   mode   = 0;
   int   cnt;
   logic run;
   logic late;

   function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic er, input bit cd);
      exp_t e;
      e.diff = d; e.bout = bo; e.err = er; e.chk_diff = cd;
      return e;
   endfunction

   function automatic logic [W:0] sub33(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Subtractor stub: mode 0 normal, 1 keeps stale done one extra cycle, 2 never done.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sub_done <= 1'b0;
         bus.sub_diff <= '0;
         bus.sub_bout <= 1'b0;
         run          <= 1'b0;
         late         <= 1'b0;
         cnt          <= 0;
      end else if (bus.sub_start) begin
         cnt  <= LAT;
         run  <= 1'b1;
         late <= (mode == 1);
         if (mode != 1) bus.sub_done <= 1'b0;
      end else begin
         if (late) begin
            late         <= 1'b0;
            bus.sub_done <= 1'b0;
         end
         if (run) begin
            if (cnt == 0) begin
               run <= 1'b0;
               if (mode != 2) begin
                  bus.sub_done                 <= 1'b1;
                  {bus.sub_bout, bus.sub_diff} <= sub33(bus.sub_a, bus.sub_b, bus.sub_bin);
               end
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && bus.sub_start) starts <= starts + 1;
   end

   // Result monitor: every accepted result is compared against the queue head.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got diff=%0h err=%0b expected none", bus.out_diff, bus.out_err);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.chk_diff) chk("out_diff", 64'(bus.out_diff), 64'(mon_e.diff));
            chk("out_bout", 64'(bus.out_bout), 64'(mon_e.bout));
            chk("out_err", 64'(bus.out_err), 64'(mon_e.err));
         end
      end
   end

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input bit exp_on, input exp_t e);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_bin   = bin;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (exp_on) sb.push_back(e);
            return;
         end
      end
      bus.in_valid = 1'b0;
      chk("push_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_valid(input int n0, output int n);
      n = n0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.out_valid) return;
      end
      chk("valid_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 1000; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      chk("drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
      chk({tag, "_sub_start"}, 64'(bus.sub_start), 64'd0);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_out_err"},   64'(bus.out_err),   64'd0);
      chk({tag, "_out_bout"},  64'(bus.out_bout),  64'd0);
      chk({tag, "_busy"},      64'(busy),          64'd0);
      chk({tag, "_sub_a"},     64'(bus.sub_a),     64'd0);
      chk({tag, "_sub_b"},     64'(bus.sub_b),     64'd0);
      chk({tag, "_sub_bin"},   64'(bus.sub_bin),   64'd0);
      chk({tag, "_out_diff"},  64'(bus.out_diff),  64'd0);
      chk({tag, "_count"},     64'(fifo_count),    64'd0);
   endtask

   logic [W-1:0] ba [7] = '{32'd10, 32'd200, 32'd0, 32'd7, 32'd100, 32'h12345678, 32'd3};
   logic [W-1:0] bb [7] = '{32'd3,  32'd100, 32'd1, 32'd7, 32'd1,   32'd1,        32'd4};
   logic         bc [7] = '{1'b0,   1'b1,    1'b0,  1'b1,  1'b0,    1'b0,         1'b1};
   logic [W-1:0] bd [7] = '{32'd7,  32'd99,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd99, 32'h12345677, 32'hFFFFFFFE};
   logic         bo [7] = '{1'b0,   1'b0,    1'b1,  1'b1,  1'b0,    1'b0,         1'b1};

   initial begin
      int n;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_bin    = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk_reset_vals("rst");
      #21;
      rst_n = 1'b1;
      #1;
      chk("in_ready_release", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Single op 50-20 with latency, one-cycle start and hold-until-ready.
      push(32'd50, 32'd20, 1'b0, 1'b1, mk(32'd30, 1'b0, 1'b0, 1'b1));
      @(negedge clk);
      chk("count_after_push", 64'(fifo_count), 64'd1);
      chk("start_before_pop", 64'(bus.sub_start), 64'd0);
      @(negedge clk);
      chk("start_issue", 64'(bus.sub_start), 64'd1);
      chk("sub_a", 64'(bus.sub_a), 64'd50);
      chk("sub_b", 64'(bus.sub_b), 64'd20);
      chk("busy_issue", 64'(busy), 64'd1);
      chk("count_after_pop", 64'(fifo_count), 64'd0);
      @(negedge clk);
      chk("start_guard", 64'(bus.sub_start), 64'd0);
      wait_valid(2, n);
      chk("latency_normal", 64'(n), 64'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_diff", 64'(bus.out_diff), 64'd30);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("valid_cleared", 64'(bus.out_valid), 64'd0);
      wait_drain();

      // Borrow cases, results in order.
      push(32'd0, 32'd15, 1'b0, 1'b1, mk(32'hFFFFFFF1, 1'b1, 1'b0, 1'b1));
      push(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, mk(32'hFFFFFFFE, 1'b0, 1'b0, 1'b1));
      wait_drain();

      // Burst of 7 with the consumer stalled: DEPTH queued plus one in flight.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(ba[i], bb[i], bc[i], 1'b1, mk(bd[i], bo[i], 1'b0, 1'b1));
      bus.in_a     = ba[5];
      bus.in_b     = bb[5];
      bus.in_bin   = bc[5];
      bus.in_valid = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      chk("full_count", 64'(fifo_count), 64'd4);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      for (int i = 5; i < 7; i++) push(ba[i], bb[i], bc[i], 1'b1, mk(bd[i], bo[i], 1'b0, 1'b1));
      wait_drain();

      // Never-done stub: timeout exactly TIMEOUT cycles after WAIT entry, then recovery.
      mode = 2;
      push(32'd7, 32'd2, 1'b0, 1'b1, mk(32'd0, 1'b0, 1'b1, 1'b0));
      wait_valid(0, n);
      chk("latency_timeout", 64'(n), 64'(TO + 3));
      chk("timeout_err", 64'(bus.out_err), 64'd1);
      wait_drain();
      mode = 0;
      push(32'd9, 32'd4, 1'b0, 1'b1, mk(32'd5, 1'b0, 1'b0, 1'b1));
      wait_drain();

      // Stale done held from the previous op must not be captured.
      push(32'd1000, 32'd1, 1'b0, 1'b1, mk(32'd999, 1'b0, 1'b0, 1'b1));
      wait_drain();
      mode = 1;
      push(32'd500, 32'd200, 1'b0, 1'b1, mk(32'd300, 1'b0, 1'b0, 1'b1));
      wait_valid(0, n);
      chk("latency_stale", 64'(n), 64'd7);
      wait_drain();

      // Asynchronous reset in WAIT with two entries queued.
      mode = 2;
      push(32'd11, 32'd1, 1'b0, 1'b0, mk(32'd0, 1'b0, 1'b0, 1'b0));
      push(32'd12, 32'd1, 1'b0, 1'b0, mk(32'd0, 1'b0, 1'b0, 1'b0));
      push(32'd13, 32'd1, 1'b0, 1'b0, mk(32'd0, 1'b0, 1'b0, 1'b0));
      repeat (4) @(posedge clk);
      #2;
      chk("pre_rst_count", 64'(fifo_count), 64'd2);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid");
      #14;
      rst_n = 1'b1;
      #1;
      chk("in_ready_rerelease", 64'(bus.in_ready), 64'd1);
      mode = 0;
      repeat (60) @(posedge clk);
      #1;
      chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_count", 64'(fifo_count), 64'd0);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("start_pulses", 64'(starts), 64'd15);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
